imem_boot_loader: RTL and testbench

Boot loader that fills the instruction memory read by the single-cycle core's ROM port (ADDR_ROM/Q_ROM) and holds that core in reset until the image is complete. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and issues one write per word to the instruction memory's write port. On completion it releases the core reset.

---
 rtl/imem_boot_loader.sv | 84 ++++++++
 tb/tb_imem_boot_loader.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a length-prefixed little-endian byte image into instruction memory,
// holding the core in reset until the final word has been written.
module imem_boot_loader #(
  parameter int SIZE       = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [7:0]            RX_DATA,
  input  logic                  RX_VALID,
  output logic                  RX_READY,
  output logic [ADDR_WIDTH-1:0] ADDR_W,
  output logic [SIZE-1:0]       Q_W,
  output logic                  ENABLE_W,
  output logic                  CORE_RESET_N,
  output logic                  DONE,
  output logic                  ERR
);
  localparam logic [2:0] HDR_LO = 3'd0;
  localparam logic [2:0] HDR_HI = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] FLUSH  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;
  localparam logic [16:0] CAP = 17'(1) << (ADDR_WIDTH - 2);
  logic [2:0]  state, nxt;
  logic [7:0]  n_lo;
  logic [15:0] n, word_cnt, n_full;
  logic [1:0]  byte_cnt;
  logic [23:0] asm_q;
  logic        take, last_byte;
  assign take      = RX_VALID & RX_READY;
  assign n_full    = {RX_DATA, n_lo};
  assign last_byte = take && state == DATA && byte_cnt == 2'd3;
  always_comb begin
    nxt = state;
    if (state == FLUSH) nxt = S_DONE;
    else if (take && state == HDR_LO) nxt = HDR_HI;
    else if (take && state == HDR_HI)
      nxt = n_full == 16'd0 ? S_DONE : {1'b0, n_full} > CAP ? S_ERR : DATA;
    else if (last_byte && word_cnt + 16'd1 == n) nxt = FLUSH;
  end
  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= HDR_LO;
      n_lo         <= '0;
      n            <= '0;
      word_cnt     <= '0;
      byte_cnt     <= '0;
      asm_q        <= '0;
      Q_W          <= '0;
      ADDR_W       <= '0;
      ENABLE_W     <= 1'b0;
      RX_READY     <= 1'b0;
      CORE_RESET_N <= 1'b0;
      DONE         <= 1'b0;
      ERR          <= 1'b0;
    end else begin
      state        <= nxt;
      RX_READY     <= nxt == HDR_LO || nxt == HDR_HI || nxt == DATA;
      DONE         <= nxt == S_DONE;
      CORE_RESET_N <= nxt == S_DONE;
      ERR          <= nxt == S_ERR;
      ENABLE_W     <= last_byte;
      if (ENABLE_W) ADDR_W <= ADDR_W + ADDR_WIDTH'(4);
      if (take && state == HDR_LO) n_lo <= RX_DATA;
      if (take && state == HDR_HI) begin
        n        <= n_full;
        word_cnt <= '0;
        byte_cnt <= '0;
        ADDR_W   <= '0;
      end
      if (take && state == DATA) begin
        byte_cnt <= byte_cnt + 2'd1;
        asm_q    <= {RX_DATA, asm_q[23:8]};
      end
      if (last_byte) begin
        Q_W      <= {RX_DATA, asm_q};
        word_cnt <= word_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: randomized loads checked against a queue of expected memory writes.
module tb_imem_boot_loader;
  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [7:0]  RX_DATA = 8'd0;
  logic        RX_VALID = 1'b0;
  logic        RX_READY, ENABLE_W, CORE_RESET_N, DONE, ERR;
  logic [9:0]  ADDR_W;
  logic [31:0] Q_W;

  imem_boot_loader dut (
    .CLK(CLK), .RESET_N(RESET_N), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .RX_READY(RX_READY), .ADDR_W(ADDR_W), .Q_W(Q_W), .ENABLE_W(ENABLE_W),
    .CORE_RESET_N(CORE_RESET_N), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {logic [9:0] a; logic [31:0] d;} wr_t;
  wr_t         exp_q[$];
  wr_t         w;
  logic [31:0] src[256];
  bit          exp_done, prev_pulse;
  int          writes = 0;
  int          checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Every write pulse must match the head of the expected-write queue.
  always @(negedge CLK) begin
    if (RESET_N) begin
      if (prev_pulse && exp_done && exp_q.size() == 0) begin
        check("done_after_last", 32'(DONE), 32'd1);
        check("core_rst_after_last", 32'(CORE_RESET_N), 32'd1);
      end
      if (ENABLE_W) begin
        writes++;
        check("pulse_done_low", 32'(DONE), 32'd0);
        check("pulse_core_rst_low", 32'(CORE_RESET_N), 32'd0);
        if (exp_q.size() == 0) check("extra_write", 32'(ENABLE_W), 32'd0);
        else begin
          w = exp_q.pop_front();
          check("addr", 32'(ADDR_W), 32'(w.a));
          check("data", Q_W, w.d);
        end
      end
    end
    prev_pulse = RESET_N && ENABLE_W;
  end

  task automatic do_reset();
    RESET_N = 1'b0;
    RX_VALID = 1'b0;
    exp_done = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge CLK);
    check("rst_ready", 32'(RX_READY), 32'd0);
    check("rst_addr", 32'(ADDR_W), 32'd0);
    check("rst_q", Q_W, 32'd0);
    check("rst_en", 32'(ENABLE_W), 32'd0);
    check("rst_core", 32'(CORE_RESET_N), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);
    RESET_N = 1'b1;
    @(negedge CLK);
    check("ready_after_rst", 32'(RX_READY), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit rdy;
    int tries = 0;
    repeat ($urandom_range(gap, 0)) begin
      @(negedge CLK);
      RX_VALID = 1'b0;
    end
    @(negedge CLK);
    RX_VALID = 1'b1;
    RX_DATA = b;
    rdy = RX_READY;
    @(posedge CLK);
    while (!rdy && tries < 50) begin
      @(negedge CLK);
      rdy = RX_READY;
      @(posedge CLK);
      tries++;
    end
    if (!rdy) check("handshake_timeout", 32'(rdy), 32'd1);
  endtask

  task automatic load(input int n, input int gap);
    logic [15:0] nn = 16'(n);
    logic [31:0] wd;
    bit valid = n >= 1 && n <= 256;
    int w0 = writes;
    exp_done = valid;
    if (valid) for (int k = 0; k < n; k++) exp_q.push_back('{10'(4 * k), src[k]});
    send_byte(nn[7:0], gap);
    send_byte(nn[15:8], gap);
    #1;
    if (n == 0) begin
      check("n0_done", 32'(DONE), 32'd1);
      check("n0_core", 32'(CORE_RESET_N), 32'd1);
    end
    if (n > 256) check("err_at_hdr", 32'(ERR), 32'd1);
    if (valid) for (int k = 0; k < n; k++) begin
      wd = src[k];
      for (int b = 0; b < 4; b++) send_byte(wd[8*b +: 8], gap);
    end
    @(negedge CLK);
    RX_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    check("pending", 32'(exp_q.size()), 32'd0);
    check("write_count", 32'(writes - w0), valid ? 32'(n) : 32'd0);
  endtask

  // Pushes junk bytes at a finished loader; nothing may change.
  task automatic stress_after(input int n);
    bit valid = n >= 1 && n <= 256;
    logic [31:0] ea = valid ? 32'((4 * n) % 1024) : 32'd0;
    logic [31:0] eq = valid ? src[n-1] : 32'd0;
    logic [31:0] ed = (n <= 256) ? 32'd1 : 32'd0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check("idle_ready", 32'(RX_READY), 32'd0);
      check("idle_en", 32'(ENABLE_W), 32'd0);
      check("idle_addr", 32'(ADDR_W), ea);
      check("idle_q", Q_W, eq);
      check("idle_done", 32'(DONE), ed);
      check("idle_core", 32'(CORE_RESET_N), ed);
      check("idle_err", 32'(ERR), 32'd1 - ed);
      RX_VALID = 1'b1;
      RX_DATA = 8'($urandom);
    end
    @(negedge CLK);
    RX_VALID = 1'b0;
  endtask

  initial begin
    int n;
    do_reset();
    src[0] = 32'h00500013;
    src[1] = 32'h00B505B3;
    load(2, 0);
    stress_after(2);

    do_reset();
    load(0, 0);
    stress_after(0);

    do_reset();
    load(257, 0);
    stress_after(257);

    do_reset();
    for (int k = 0; k < 256; k++) src[k] = $urandom;
    load(256, 3);
    stress_after(256);

    do_reset();
    src[0] = $urandom;
    src[1] = $urandom;
    exp_q.push_back('{10'd0, src[0]});
    send_byte(8'd2, 0);
    send_byte(8'd0, 0);
    for (int b = 0; b < 6; b++) send_byte(src[b / 4][8*(b % 4) +: 8], 0);
    #1 RESET_N = 1'b0;
    #1;
    check("abort_core", 32'(CORE_RESET_N), 32'd0);
    check("abort_en", 32'(ENABLE_W), 32'd0);
    check("abort_pending", 32'(exp_q.size()), 32'd0);
    do_reset();
    src[0] = 32'hDEADBEEF;
    load(1, 0);
    stress_after(1);

    for (int t = 0; t < 4; t++) begin
      do_reset();
      n = $urandom_range(20, 1);
      for (int k = 0; k < n; k++) src[k] = $urandom;
      load(n, 3);
      stress_after(n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
